// File: rtl/jtag_pkg.sv
// Shared JTAG master types: command opcodes, FSM states, TAP instruction and TMS pattern constants.
package jtag_pkg;

  typedef enum logic [1:0] {
    OP_RESET    = 2'd0,
    OP_IR_SCAN  = 2'd1,
    OP_DR_SCAN  = 2'd2,
    OP_IDLE_RUN = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_SEQ,
    ST_HDR,
    ST_SHIFT,
    ST_TRAIL,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int IR_W = 3;
  localparam logic [IR_W-1:0] IR_BYPASS  = 3'b111;
  localparam logic [IR_W-1:0] IR_IDCODE  = 3'b001;
  localparam logic [IR_W-1:0] IR_SAMPLE  = 3'b010;
  localparam logic [IR_W-1:0] IR_PRELOAD = 3'b011;
  localparam logic [IR_W-1:0] IR_INTEST  = 3'b100;
  localparam logic [IR_W-1:0] IR_EXTEST  = 3'b101;

  localparam logic [31:0] IDCODE_VAL = 32'h06C6_2127;

  // TMS sequences, first period in bit 0.
  localparam logic [5:0] TMS_RST    = 6'b011111;
  localparam logic [5:0] TMS_IR_HDR = 6'b000011;
  localparam logic [5:0] TMS_DR_HDR = 6'b000001;
  localparam logic [5:0] TMS_TRAIL  = 6'b000001;

  function automatic logic is_scan(input op_t op);
    return (op == OP_IR_SCAN) || (op == OP_DR_SCAN);
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: TCK_DIV clks low then TCK_DIV clks high while enabled, parked low otherwise.
// o_rise_stb marks the last low clk (TDO capture), o_fall_stb the last high clk (TMS/TDI update).
module jtag_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_tck,
  output logic o_fall_stb,
  output logic o_rise_stb
);

  localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_tck;
  logic          w_end;

  assign w_end      = i_en && (r_cnt == CW'(TCK_DIV - 1));
  assign o_tck      = r_tck;
  assign o_rise_stb = w_end && !r_tck;
  assign o_fall_stb = w_end && r_tck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_tck <= 1'b0;
    end else if (!i_en) begin
      r_cnt <= '0;
      r_tck <= 1'b0;
    end else if (w_end) begin
      r_cnt <= '0;
      r_tck <= ~r_tck;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/jtag_master.sv
// JTAG master: walks the TAP through reset / IR scan / DR scan / idle-run per command and
// returns captured TDO right-aligned. Each FSM segment loads a TMS pattern and a period count.
module jtag_master
  import jtag_pkg::*;
#(
  parameter int TCK_DIV = 2,
  parameter int DR_MAX  = 32,
  parameter int LEN_W   = $clog2(DR_MAX) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DR_MAX-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DR_MAX-1:0] rsp_data,
  output logic              busy,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
);

  state_t            r_state;
  op_t               r_op;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic [5:0]        r_pat;
  logic [DR_MAX-1:0] r_data;
  logic [DR_MAX-1:0] r_cap;
  logic [DR_MAX-1:0] r_rsp_data;
  logic              r_rsp_valid;
  logic              r_synced;
  logic              r_tms;
  logic              r_tdi;

  logic              w_ready;
  logic              w_fall;
  logic              w_rise;
  logic              w_tck;
  logic [LEN_W-1:0]  w_len_clamp;
  op_t               w_op;
  logic [LEN_W-1:0]  w_len;
  logic              w_data0;
  state_t            w_after_rst;
  state_t            w_tgt;
  logic [5:0]        w_tgt_pat;
  logic [LEN_W-1:0]  w_tgt_cnt;
  logic              w_tgt_tdi;

  assign w_ready   = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign cmd_ready = w_ready;
  assign busy      = ~w_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign tck       = w_tck;
  assign tms       = r_tms;
  assign tdi       = r_tdi;

  jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (~w_ready),
    .o_tck      (w_tck),
    .o_fall_stb (w_fall),
    .o_rise_stb (w_rise)
  );

  // Scan lengths clamp to 1..DR_MAX; IDLE_RUN keeps the raw count, zero included.
  always_comb begin
    w_len_clamp = cmd_len;
    if (op_t'(cmd_op) != OP_IDLE_RUN) begin
      if (cmd_len == '0)
        w_len_clamp = LEN_W'(1);
      else if (cmd_len > LEN_W'(DR_MAX))
        w_len_clamp = LEN_W'(DR_MAX);
    end
  end

  // Next segment and its load values; command fields come straight from the inputs when idle.
  always_comb begin
    w_op    = w_ready ? op_t'(cmd_op) : r_op;
    w_len   = w_ready ? w_len_clamp : r_len;
    w_data0 = w_ready ? cmd_data[0] : r_data[0];

    if (w_op == OP_RESET)
      w_after_rst = ST_DONE;
    else if (w_op == OP_IDLE_RUN)
      w_after_rst = (w_len == '0) ? ST_DONE : ST_RUN;
    else
      w_after_rst = ST_HDR;

    case (r_state)
      ST_IDLE, ST_DONE: w_tgt = (!r_synced || w_op == OP_RESET) ? ST_RST_SEQ : w_after_rst;
      ST_RST_SEQ:       w_tgt = w_after_rst;
      ST_HDR:           w_tgt = ST_SHIFT;
      ST_SHIFT:         w_tgt = ST_TRAIL;
      default:          w_tgt = ST_DONE;
    endcase

    w_tgt_pat = '0;
    w_tgt_cnt = '0;
    w_tgt_tdi = 1'b0;
    case (w_tgt)
      ST_RST_SEQ: begin
        w_tgt_pat = TMS_RST;
        w_tgt_cnt = LEN_W'(5);
      end
      ST_HDR: begin
        w_tgt_pat = (w_op == OP_IR_SCAN) ? TMS_IR_HDR : TMS_DR_HDR;
        w_tgt_cnt = (w_op == OP_IR_SCAN) ? LEN_W'(3) : LEN_W'(2);
      end
      ST_SHIFT: begin
        w_tgt_pat = {5'b0, (w_len == LEN_W'(1))};
        w_tgt_cnt = w_len - LEN_W'(1);
        w_tgt_tdi = w_data0;
      end
      ST_TRAIL: begin
        w_tgt_pat = TMS_TRAIL;
        w_tgt_cnt = LEN_W'(1);
      end
      ST_RUN:  w_tgt_cnt = w_len - LEN_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_RESET;
      r_len       <= '0;
      r_cnt       <= '0;
      r_pat       <= '0;
      r_data      <= '0;
      r_cap       <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_synced    <= 1'b0;
      r_tms       <= 1'b0;
      r_tdi       <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_ready) begin
        if (cmd_valid) begin
          r_op    <= op_t'(cmd_op);
          r_len   <= w_len_clamp;
          r_data  <= cmd_data;
          r_cap   <= '0;
          r_state <= w_tgt;
          r_pat   <= w_tgt_pat;
          r_cnt   <= w_tgt_cnt;
          r_tms   <= w_tgt_pat[0];
          r_tdi   <= w_tgt_tdi;
          if (w_tgt == ST_DONE) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= '0;
          end
        end else begin
          r_state <= ST_IDLE;
        end
      end else if (w_fall) begin
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - LEN_W'(1);
          r_pat <= r_pat >> 1;
          if (r_state == ST_SHIFT) begin
            r_tms  <= (r_cnt == LEN_W'(1));
            r_tdi  <= r_data[1];
            r_data <= r_data >> 1;
          end else begin
            r_tms <= r_pat[1];
          end
        end else begin
          r_state <= w_tgt;
          r_pat   <= w_tgt_pat;
          r_cnt   <= w_tgt_cnt;
          r_tms   <= w_tgt_pat[0];
          r_tdi   <= w_tgt_tdi;
          if (r_state == ST_RST_SEQ)
            r_synced <= 1'b1;
          if (w_tgt == ST_DONE) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= is_scan(r_op) ? (r_cap >> (LEN_W'(DR_MAX) - r_len)) : '0;
          end
        end
      end
      // TDO enters at the MSB so the last bit lands in place; DONE right-aligns by length.
      if (w_rise && r_state == ST_SHIFT)
        r_cap <= {tdo, r_cap[DR_MAX-1:1]};
    end
  end

endmodule
